// File: rtl/serializer.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word when idle and shifts it out LSB first, DIV cycles per bit.
// First bit appears the cycle after acceptance; load is ignored (no backpressure queue) while a frame is in flight.
module serializer #(
    parameter int WIDTH = 5,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d   = SHIFT;
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    valid_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    // Zero fill leaves the register clear by the end of a frame, so sout idles low.
                    shreg_d   = shreg_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        valid_d   = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready      = (state_q == IDLE);
    assign sout       = shreg_q[0];
    assign sout_valid = valid_q;
    assign done       = done_q;

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning the word length in bits (legal range 2..16).
REQ-002 SHALL have parameter DIV, default 1, meaning the clock cycles each bit is held on sout (legal range 1..16).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port load  input  1  request to accept data_in.
REQ-007 SHALL have port ready  output  1  high when a load is accepted on the next rising edge.
REQ-008 SHALL have port sout  output  1  serial data, LSB first.
REQ-009 SHALL have port sout_valid  output  1  high while sout carries a frame bit.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 SHALL implement two states, IDLE and SHIFT, plus a WIDTH-bit shift register, a bit counter (0..WIDTH-1) and a divide counter (0..DIV-1).
REQ-012 SHALL drive ready=1 only in IDLE and ready=0 in SHIFT.
REQ-013 SHALL accept a word only on a rising edge where load=1 and ready=1: capture data_in, clear both counters, enter SHIFT.
REQ-014 SHALL ignore load when ready=0, with no effect on state, data or outputs.
REQ-015 SHALL drive sout = shift register bit 0 and sout_valid=1 throughout SHIFT; sout=0 and sout_valid=0 in IDLE.
REQ-016 SHALL increment the divide counter on every SHIFT edge; when it equals DIV-1, it clears, the shift register shifts right by one with 0 filled at the MSB, and the bit counter increments.
REQ-017 SHALL return to IDLE on the edge where the divide counter is DIV-1 and the bit counter is WIDTH-1, and set done=1 for exactly the following cycle.
REQ-018 SHALL hold every bit for exactly DIV cycles, giving sout_valid high for WIDTH*DIV consecutive cycles per frame.
REQ-019 SHALL reach ready=1 in the same cycle done=1, so the minimum load-to-load spacing is WIDTH*DIV+1 cycles.
REQ-020 SHALL register all outputs except ready, which is decoded from state only; outputs SHALL have no combinational path from load or data_in.
REQ-021 SHALL not alter the frame in flight if data_in changes after acceptance.

Reset
REQ-022 SHALL, while reset=1 and independent of clk, force IDLE, shift register=0, both counters=0, sout=0, sout_valid=0, done=0, ready=1.
REQ-023 SHALL, if reset is asserted mid-frame, abandon the frame with no done pulse, and accept a new load on the first edge after reset deasserts.

Verification
REQ-024 SHALL pass: WIDTH=5, DIV=1, load 5'b10110 at edge E0 -> sout=0,1,1,0,1 in cycles after E0..E4, sout_valid high those 5 cycles, done=1 and ready=1 in the cycle after E5 only.
REQ-025 SHALL pass: WIDTH=5, DIV=3, load 5'b00011 -> sout=1 for 6 cycles then 0 for 9 cycles, sout_valid high 15 cycles, single done pulse.
REQ-026 SHALL pass: load held high continuously with data_in changing every cycle -> words captured only on edges with ready=1, each frame matches its captured word, 6-cycle spacing at DIV=1.
REQ-027 SHALL pass: reset asserted during bit 2 of 5'b11111 -> sout=0, sout_valid=0, ready=1 immediately (before the next edge), no done; next load 5'b00001 transmits 1,0,0,0,0.
REQ-028 SHALL pass: loop-back into a 5-bit right-shifting SIPO register (serial input enters MSB), clocked only while sout_valid=1 -> its parallel output equals the loaded word once done=1, for all 32 values.
REQ-029 SHALL pass: load asserted with ready=0 mid-frame -> frame and done timing unchanged, word not captured.
